// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write port, asynchronous read port, no reset.
module instr_mem
  import riscv_pkg::*;
#(
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [AddrW-1:0]   wr_addr_i,
  input  logic [INSTR_W-1:0] wr_data_i,
  input  logic [AddrW-1:0]   rd_addr_i,
  output logic [INSTR_W-1:0] rd_data_o
);

  logic [INSTR_W-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, load/run/halt FSM and registered instruction output.
// Optional macro HALT_ON_ZERO_EN: an all-zero fetched word halts instead of issuing.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imem_wr_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_wr_addr,
  input  logic [31:0]                   imem_wr_data,
  input  logic                          start,
  input  logic                          stall,
  input  logic                          redirect_en,
  input  logic [31:0]                   redirect_pc,
  output logic [31:0]                   instruction,
  output logic [31:0]                   pc_out,
  output logic                          instr_valid,
  output logic                          halted,
  output logic                          fetch_err
);

  localparam int unsigned AW       = $clog2(IMEM_DEPTH);
  localparam logic [31:0] MemBytes = 32'(IMEM_DEPTH) << 2;
  localparam logic [AW-1:0] LastIdx = AW'(IMEM_DEPTH - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic [31:0]  rd_data;
  logic         pc_in_range;
  logic         last_word;
  logic         zero_stop;

  instr_mem #(
    .Depth (IMEM_DEPTH)
  ) u_instr_mem (
    .clk_i     (clk),
    .wr_en_i   (imem_wr_en && (state_q != StFetch)),
    .wr_addr_i (imem_wr_addr),
    .wr_data_i (imem_wr_data),
    .rd_addr_i (pc_q[AW+1:2]),
    .rd_data_o (rd_data)
  );

  assign pc_in_range = (pc_q < MemBytes);
  assign last_word   = (pc_q[AW+1:2] == LastIdx);

`ifdef HALT_ON_ZERO_EN
  assign zero_stop = (rd_data == '0);
`else
  assign zero_stop = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = RESET_PC;
        end
      end
      StFetch: begin
        if (redirect_en) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d = StHalt;
            err_d   = 1'b1;
          end
        end else if (!stall) begin
          if (!pc_in_range) begin
            state_d = StHalt;
            err_d   = 1'b1;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end else if (zero_stop) begin
            state_d = StHalt;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end else begin
            instr_d  = rd_data;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            // No wrap: the last word issues and the FSM halts on the same edge.
            if (last_word) begin
              state_d = StHalt;
            end
          end
        end
      end
      StHalt: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (start) begin
          state_d = StFetch;
          pc_d    = RESET_PC;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= 32'h0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == StHalt);
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a 64-word instance and a 4-word instance for the end-of-memory case.
module tb_instr_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic [31:0] instruction, pc_out;
  logic        instr_valid, halted, fetch_err;

  logic        wr_en4 = 1'b0;
  logic [1:0]  wr_addr4 = '0;
  logic [31:0] wr_data4 = '0;
  logic        start4 = 1'b0;
  logic        stall4 = 1'b0;
  logic        redir4 = 1'b0;
  logic [31:0] redir_pc4 = '0;
  logic [31:0] instruction4, pc_out4;
  logic        instr_valid4, halted4, fetch_err4;

  logic [66:0] obs, obs4, exp;
  logic [31:0] prog [6];
  logic [31:0] w4 [4];
  int          checks = 0;
  int          errors = 0;

  assign obs  = {instruction, pc_out, instr_valid, halted, fetch_err};
  assign obs4 = {instruction4, pc_out4, instr_valid4, halted4, fetch_err4};

  always #5 clk = ~clk;

  instr_fetch #(
    .IMEM_DEPTH (64),
    .RESET_PC   (32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_wr_en   (wr_en),
    .imem_wr_addr (wr_addr),
    .imem_wr_data (wr_data),
    .start        (start),
    .stall        (stall),
    .redirect_en  (redir),
    .redirect_pc  (redir_pc),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .fetch_err    (fetch_err)
  );

  instr_fetch #(
    .IMEM_DEPTH (4),
    .RESET_PC   (32'h0)
  ) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_wr_en   (wr_en4),
    .imem_wr_addr (wr_addr4),
    .imem_wr_data (wr_data4),
    .start        (start4),
    .stall        (stall4),
    .redirect_en  (redir4),
    .redirect_pc  (redir_pc4),
    .instruction  (instruction4),
    .pc_out       (pc_out4),
    .instr_valid  (instr_valid4),
    .halted       (halted4),
    .fetch_err    (fetch_err4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    exp = {Nop, 32'h0, 3'b000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset: got %h want %h", obs, exp); end
    checks++;
    if (obs4 !== exp) begin errors++; $display("FAIL reset4: got %h want %h", obs4, exp); end
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_depth4_end();
    w4[0] = 32'h0010_0093; w4[1] = 32'h0020_0113; w4[2] = 32'h0030_0193; w4[3] = 32'h0040_0213;
    for (int i = 0; i < 4; i++) begin
      wr_en4 = 1'b1; wr_addr4 = 2'(i); wr_data4 = w4[i];
      step();
    end
    wr_en4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = {w4[i], 32'(i * 4), 1'b1, (i == 3), 1'b0};
      checks++;
      if (obs4 !== exp) begin errors++; $display("FAIL d4_run%0d: got %h want %h", i, obs4, exp); end
    end
    step();
    exp = {Nop, 32'hC, 3'b010};
    checks++;
    if (obs4 !== exp) begin errors++; $display("FAIL d4_nowrap: got %h want %h", obs4, exp); end
  endtask

  task automatic test_load_run();
    prog[0] = 32'h0050_0093; prog[1] = 32'h0030_0113; prog[2] = 32'h0020_81B3;
    prog[3] = 32'h4020_8233; prog[4] = 32'h00A0_0213; prog[5] = 32'h00B0_0293;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = prog[i];
      step();
    end
    wr_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    exp = {Nop, 32'h0, 3'b000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL run_lat: got %h want %h", obs, exp); end
    step();
    exp = {prog[0], 32'h0, 3'b100};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL run_w0: got %h want %h", obs, exp); end
    step();
    exp = {prog[1], 32'h4, 3'b100};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL run_w1: got %h want %h", obs, exp); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      exp = {prog[1], 32'h4, 3'b100};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall%0d: got %h want %h", i, obs, exp); end
    end
    stall = 1'b0;
    step();
    exp = {prog[2], 32'h8, 3'b100};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL stall_release: got %h want %h", obs, exp); end
  endtask

  task automatic test_redirect();
    redir = 1'b1; redir_pc = 32'h10; stall = 1'b1;
    step();
    redir = 1'b0; stall = 1'b0;
    exp = {Nop, 32'h8, 3'b000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL redir_bubble: got %h want %h", obs, exp); end
    step();
    exp = {prog[4], 32'h10, 3'b100};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL redir_target: got %h want %h", obs, exp); end
  endtask

  task automatic test_misaligned();
    redir = 1'b1; redir_pc = 32'h6;
    step();
    redir = 1'b0;
    exp = {Nop, 32'h10, 3'b011};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL misalign: got %h want %h", obs, exp); end
    step();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL misalign_hold: got %h want %h", obs, exp); end
    // Write and start together from HALT: the new word must be the first fetched.
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = 32'h1111_1113; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    exp = {Nop, 32'h10, 3'b000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL restart_clear: got %h want %h", obs, exp); end
    step();
    exp = {32'h1111_1113, 32'h0, 3'b100};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL restart_w0: got %h want %h", obs, exp); end
  endtask

  task automatic test_fetch_write_ignored();
    wr_en = 1'b1; wr_addr = 6'd2; wr_data = 32'hDEAD_BEEF;
    step();
    wr_en = 1'b0;
    exp = {prog[1], 32'h4, 3'b100};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL fetchwr_w1: got %h want %h", obs, exp); end
    step();
    exp = {prog[2], 32'h8, 3'b100};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL fetchwr_w2: got %h want %h", obs, exp); end
  endtask

  task automatic test_out_of_range();
    redir = 1'b1; redir_pc = 32'h100;
    step();
    redir = 1'b0;
    exp = {Nop, 32'h8, 3'b000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL oor_bubble: got %h want %h", obs, exp); end
    step();
    exp = {Nop, 32'h8, 3'b011};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL oor_halt: got %h want %h", obs, exp); end
  endtask

  task automatic test_zero_word();
    wr_en = 1'b1; wr_addr = 6'd1; wr_data = 32'h0; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    exp = {Nop, 32'h8, 3'b000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_restart: got %h want %h", obs, exp); end
    step();
    exp = {32'h1111_1113, 32'h0, 3'b100};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_w0: got %h want %h", obs, exp); end
    step();
`ifdef HALT_ON_ZERO_EN
    exp = {Nop, 32'h0, 3'b010};
`else
    exp = {32'h0, 32'h4, 3'b100};
`endif
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_w1: got %h want %h", obs, exp); end
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    exp = {Nop, 32'h0, 3'b000};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL midreset: got %h want %h", obs, exp); end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL midreset_idle: got %h want %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_depth4_end();
    test_load_run();
    test_stall();
    test_redirect();
    test_misaligned();
    test_fetch_write_ignored();
    test_out_of_range();
    test_zero_word();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
